// File: rtl/accumulator_n_if.sv
// Operation/result handshake bundle for accumulator_n.
// The master drives operations and consumes results; the slave is the accumulator.
interface accumulator_n_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] datain;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataout;
  logic             out_valid;
  logic             out_ready;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output enable, mode, datain, in_valid, out_ready,
    input  in_ready, dataout, out_valid, carry, overflow, zero
  );

  modport slave (
    input  enable, mode, datain, in_valid, out_ready,
    output in_ready, dataout, out_valid, carry, overflow, zero
  );
endinterface

// File: rtl/accumulator_n.sv
// Signed accumulator with LOAD/ADD/SUB/CLEAR, carry/overflow flags, optional
// saturation, and a single-entry valid/ready result stage that is the accumulator itself.
module accumulator_n #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  accumulator_n_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_ADD   = 2'b01,
    MODE_SUB   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.enable & bus.in_valid & in_ready;

  always_comb begin
    acc_d       = acc_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    ovf         = 1'b0;
    sum         = {1'b0, acc_q} + {1'b0, bus.datain};
    // Top bit of the zero-extended difference is the unsigned borrow.
    diff        = {1'b0, acc_q} - {1'b0, bus.datain};

    if (accept) begin
      out_valid_d = 1'b1;
      unique case (mode_e'(bus.mode))
        MODE_LOAD: begin
          acc_d      = bus.datain;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
        end
        MODE_ADD: begin
          ovf        = (acc_q[WIDTH-1] == bus.datain[WIDTH-1]) &&
                       (sum[WIDTH-1] != acc_q[WIDTH-1]);
          acc_d      = sum[WIDTH-1:0];
          carry_d    = sum[WIDTH];
          overflow_d = ovf;
        end
        MODE_SUB: begin
          ovf        = (acc_q[WIDTH-1] != bus.datain[WIDTH-1]) &&
                       (diff[WIDTH-1] != acc_q[WIDTH-1]);
          acc_d      = diff[WIDTH-1:0];
          carry_d    = diff[WIDTH];
          overflow_d = ovf;
        end
        MODE_CLEAR: begin
          acc_d      = '0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
        end
        default: ;
      endcase
      // On overflow the accumulator's own sign tells the direction in both ADD and SUB.
      if (SATURATE && ovf) begin
        acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dataout   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = (acc_q == '0);
endmodule

// File: tb/tb_accumulator_n.sv
// Drives three accumulator_n instances (8-bit wrap, 8-bit saturate, 16-bit wrap)
// with one shared operation stream and checks them against a scoreboard.
module tb_accumulator_n;
  logic        clk = 1'b0;
  logic        reset;
  logic        en, iv, ordy;
  logic [1:0]  md;
  logic [31:0] din;

  always #5 clk = ~clk;

  accumulator_n_if #(.WIDTH(8))  b8 ();
  accumulator_n_if #(.WIDTH(8))  bs ();
  accumulator_n_if #(.WIDTH(16)) b16 ();

  assign b8.enable  = en;  assign b8.mode  = md; assign b8.in_valid  = iv; assign b8.out_ready  = ordy;
  assign bs.enable  = en;  assign bs.mode  = md; assign bs.in_valid  = iv; assign bs.out_ready  = ordy;
  assign b16.enable = en;  assign b16.mode = md; assign b16.in_valid = iv; assign b16.out_ready = ordy;
  assign b8.datain  = din[7:0];
  assign bs.datain  = din[7:0];
  assign b16.datain = din[15:0];

  accumulator_n #(.WIDTH(8),  .SATURATE(1'b0)) u_w8  (.clk(clk), .reset(reset), .bus(b8.slave));
  accumulator_n #(.WIDTH(8),  .SATURATE(1'b1)) u_s8  (.clk(clk), .reset(reset), .bus(bs.slave));
  accumulator_n #(.WIDTH(16), .SATURATE(1'b0)) u_w16 (.clk(clk), .reset(reset), .bus(b16.slave));

  logic [31:0] o_acc [3];
  logic        o_c [3], o_v [3], o_z [3], o_ov [3], o_ir [3];
  assign o_acc[0] = 32'(b8.dataout);  assign o_acc[1] = 32'(bs.dataout);  assign o_acc[2] = 32'(b16.dataout);
  assign o_c[0]  = b8.carry;     assign o_c[1]  = bs.carry;     assign o_c[2]  = b16.carry;
  assign o_v[0]  = b8.overflow;  assign o_v[1]  = bs.overflow;  assign o_v[2]  = b16.overflow;
  assign o_z[0]  = b8.zero;      assign o_z[1]  = bs.zero;      assign o_z[2]  = b16.zero;
  assign o_ov[0] = b8.out_valid; assign o_ov[1] = bs.out_valid; assign o_ov[2] = b16.out_valid;
  assign o_ir[0] = b8.in_ready;  assign o_ir[1] = bs.in_ready;  assign o_ir[2] = b16.in_ready;

  typedef struct packed {
    logic [2:0][31:0] acc;
    logic [2:0]       c;
    logic [2:0]       v;
  } exp_t;

  exp_t   m;
  exp_t   sbq [$];
  logic   exp_ov;
  int     tests = 0;
  int     fails = 0;
  int     wid [3] = '{8, 8, 16};
  bit     sat [3] = '{1'b0, 1'b1, 1'b0};

  // Reference: exact signed arithmetic in 64 bits, then wrap or clamp.
  function automatic logic [33:0] model(input logic [31:0] acc, input logic [1:0] mode,
                                        input logic [31:0] d, input int w, input bit s_en);
    longint mod  = 64'sd1 <<< w;
    longint half = mod / 2;
    longint au   = longint'(acc) & (mod - 1);
    longint du   = longint'(d) & (mod - 1);
    longint as_  = (au >= half) ? au - mod : au;
    longint ds_  = (du >= half) ? du - mod : du;
    longint s    = 0;
    longint r;
    logic   c    = 1'b0;
    logic   v;
    case (mode)
      2'b00: s = ds_;
      2'b01: begin s = as_ + ds_; c = (au + du) >= mod; end
      2'b10: begin s = as_ - ds_; c = au < du; end
      default: s = 0;
    endcase
    v = (s > half - 1) || (s < -half);
    r = s & (mod - 1);
    if (s_en && v) r = (s > 0) ? half - 1 : half;
    return {c, v, r[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d].dataout", tag, i), o_acc[i], m.acc[i]);
      check($sformatf("%s[%0d].carry", tag, i), 32'(o_c[i]), 32'(m.c[i]));
      check($sformatf("%s[%0d].overflow", tag, i), 32'(o_v[i]), 32'(m.v[i]));
      check($sformatf("%s[%0d].zero", tag, i), 32'(o_z[i]), 32'(m.acc[i] == 32'd0));
      check($sformatf("%s[%0d].out_valid", tag, i), 32'(o_ov[i]), 32'(exp_ov));
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks after the next edge.
  task automatic step(input string tag, input logic e, input logic [1:0] mo,
                      input logic [31:0] d, input logic v, input logic r);
    logic acc_ok;
    exp_t nx;
    en = e; md = mo; din = d; iv = v; ordy = r;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("%s[%0d].in_ready", tag, i), 32'(o_ir[i]), 32'(!exp_ov || r));
    acc_ok = e && v && (!exp_ov || r);
    if (acc_ok) begin
      for (int i = 0; i < 3; i++)
        {nx.c[i], nx.v[i], nx.acc[i]} = model(m.acc[i], mo, d, wid[i], sat[i]);
      sbq.push_back(nx);
    end
    @(posedge clk);
    #1;
    if (acc_ok) begin
      exp_ov = 1'b1;
      m = sbq.pop_front();
    end else if (r) begin
      exp_ov = 1'b0;
    end
    iv = 1'b0;
    check_all(tag);
  endtask

  initial begin
    m = '0; exp_ov = 1'b0;
    en = 1'b1; md = 2'b00; din = '0; iv = 1'b0; ordy = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_all("reset");
    for (int i = 0; i < 3; i++) check($sformatf("reset[%0d].in_ready", i), 32'(o_ir[i]), 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Signed overflow: wrap versus saturate
    step("ld7f", 1, 2'b00, 32'h7F, 1, 1);
    step("add1", 1, 2'b01, 32'h01, 1, 1);
    check("r032_dout", o_acc[0], 32'h80);
    check("r032_ovf", 32'(o_v[0]), 32'd1);
    check("r032_carry", 32'(o_c[0]), 32'd0);
    check("r032_zero", 32'(o_z[0]), 32'd0);
    check("r033_sat_dout", o_acc[1], 32'h7F);
    check("r033_sat_ovf", 32'(o_v[1]), 32'd1);
    step("ld80", 1, 2'b00, 32'h80, 1, 1);
    step("sub1", 1, 2'b10, 32'h01, 1, 1);
    check("r033_neg_dout", o_acc[1], 32'h80);
    check("r033_neg_ovf", 32'(o_v[1]), 32'd1);

    // Zero result and borrow
    step("ld05", 1, 2'b00, 32'h05, 1, 1);
    step("sub05", 1, 2'b10, 32'h05, 1, 1);
    check("r034_zero", 32'(o_z[0]), 32'd1);
    check("r034_carry0", 32'(o_c[0]), 32'd0);
    step("sub01", 1, 2'b10, 32'h01, 1, 1);
    check("r034_dout", o_acc[0], 32'hFF);
    check("r034_borrow", 32'(o_c[0]), 32'd1);

    // 16-bit unsigned carry without signed overflow, then enable gating
    step("ldffff", 1, 2'b00, 32'hFFFF, 1, 1);
    step("add0001", 1, 2'b01, 32'h0001, 1, 1);
    check("r037_dout", o_acc[2], 32'h0000);
    check("r037_carry", 32'(o_c[2]), 32'd1);
    check("r037_ovf", 32'(o_v[2]), 32'd0);
    step("en0", 0, 2'b00, 32'h1234, 1, 1);
    check("r037_hold", o_acc[2], 32'h0000);

    // Backpressure: result held, no accept, then accept on release
    step("add10", 1, 2'b01, 32'h10, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stall%0d", k), 1, 2'b01, 32'h22, 1, 0);
      check($sformatf("r035_hold%0d", k), o_acc[0], 32'h10);
    end
    step("release", 1, 2'b01, 32'h22, 1, 1);
    check("r035_accept", o_acc[0], 32'h32);
    step("drain", 1, 2'b00, 32'h00, 0, 1);

    // Asynchronous reset while a result is pending
    step("ld3c", 1, 2'b00, 32'h3C, 1, 1);
    step("stallr", 1, 2'b01, 32'h01, 1, 0);
    #2 reset = 1'b0;
    #1;
    m = '0; exp_ov = 1'b0; sbq.delete();
    check_all("r036");
    check("r036_dout", o_acc[0], 32'h00);
    for (int i = 0; i < 3; i++) check($sformatf("r036[%0d].in_ready", i), 32'(o_ir[i]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step("postrst", 1, 2'b01, 32'h05, 1, 1);
    check("r030_from0", o_acc[0], 32'h05);

    // CLEAR ignores datain
    step("ld12", 1, 2'b00, 32'h12, 1, 1);
    step("clr", 1, 2'b11, 32'hFF, 1, 1);

    // Mixed traffic with random backpressure
    for (int k = 0; k < 40; k++)
      step($sformatf("rnd%0d", k), 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
